// File: rtl/cnn_sched_pkg.sv
// Shared types, default layer table and helpers for the CNN layer scheduler.
package cnn_sched_pkg;

  localparam int NUM_LAYERS_D = 4;
  localparam int CH_W_D       = 7;
  localparam int LAYER_W_D    = 2;

  // Output-channel count per layer, layer 0 at index 0: conv1=6, dw2=16, fc1=84, fc2=10
  localparam logic [NUM_LAYERS_D-1:0][CH_W_D-1:0] LAYER_CH_D = {7'd10, 7'd84, 7'd16, 7'd6};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SWAP, RESULT, ERROR} sched_state_t;

  // Number of engine jobs one full run issues for a given layer table.
  function automatic int total_jobs(input logic [NUM_LAYERS_D-1:0][CH_W_D-1:0] tbl);
    int n;
    n = 0;
    for (int i = 0; i < NUM_LAYERS_D; i++) n += int'(tbl[i]);
    return n;
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Per-job watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th enabled cycle, so a completion in that same cycle still wins.
module sched_watchdog #(
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  // Cycle counter; holds once the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (clear)               r_cnt <= '0;
    else if (enable && !expired)  r_cnt <= r_cnt + TO_W'(1);
  end

  assign expired = enable && (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Walks the shared compute engine through every (layer, channel) job,
// swaps the ping-pong activation bank between layers and hands off the result.
module cnn_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_D,
  parameter int CH_W       = CH_W_D,
  parameter int LAYER_W    = LAYER_W_D,
  parameter logic [NUM_LAYERS-1:0][CH_W-1:0] LAYER_CH = LAYER_CH_D,
  parameter int TIMEOUT    = 65535,
  parameter int TO_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               eng_start,
  output logic [LAYER_W-1:0] eng_layer,
  output logic [CH_W-1:0]    eng_ch,
  input  logic               eng_done,
  output logic               buf_swap,
  output logic               buf_sel,
  output logic               res_valid,
  input  logic               res_ready
);

  // Parameter sanity, caught at elaboration.
  if ((2 ** LAYER_W) < NUM_LAYERS) begin : g_bad_lw
    $error("LAYER_W too narrow for NUM_LAYERS");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (2 ** TO_W)) begin : g_bad_to
    $error("TIMEOUT must be >= 1 and fit in TO_W bits");
  end
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_chk
    if (LAYER_CH[gi] == '0) begin : g_bad_ch
      $error("LAYER_CH entries must be >= 1");
    end
  end

  sched_state_t       r_state, w_state;
  logic [LAYER_W-1:0] r_layer, w_layer;
  logic [CH_W-1:0]    r_ch, w_ch;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               r_eng_start, w_eng_start;
  logic               r_buf_swap, w_buf_swap;
  logic               r_buf_sel, w_buf_sel;
  logic               r_res_valid, w_res_valid;
  logic [CH_W-1:0]    w_last_ch;
  logic               w_wd_exp;

  assign w_last_ch = LAYER_CH[r_layer] - CH_W'(1);

  sched_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == ISSUE),
    .enable  (r_state == WAIT),
    .expired (w_wd_exp)
  );

  // Next state and next values of every registered output; abort overrides all.
  always_comb begin
    w_state     = r_state;
    w_layer     = r_layer;
    w_ch        = r_ch;
    w_busy      = r_busy;
    w_err       = r_err;
    w_buf_sel   = r_buf_sel;
    w_done      = 1'b0;
    w_eng_start = 1'b0;
    w_buf_swap  = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      IDLE, ERROR: begin
        if (start) begin
          w_state     = ISSUE;
          w_layer     = '0;
          w_ch        = '0;
          w_buf_sel   = 1'b0;
          w_err       = 1'b0;
          w_busy      = 1'b1;
          w_eng_start = 1'b1;
        end
      end
      ISSUE: w_state = WAIT;
      WAIT: begin
        if (eng_done) begin
          if (r_ch < w_last_ch) begin
            w_ch        = r_ch + CH_W'(1);
            w_state     = ISSUE;
            w_eng_start = 1'b1;
          end else if (r_layer < LAYER_W'(NUM_LAYERS - 1)) begin
            // bank flips together with the swap pulse
            w_state    = SWAP;
            w_buf_swap = 1'b1;
            w_buf_sel  = ~r_buf_sel;
          end else begin
            w_state     = RESULT;
            w_res_valid = 1'b1;
          end
        end else if (w_wd_exp) begin
          w_state = ERROR;
          w_err   = 1'b1;
          w_busy  = 1'b0;
        end
      end
      SWAP: begin
        w_layer     = r_layer + LAYER_W'(1);
        w_ch        = '0;
        w_state     = ISSUE;
        w_eng_start = 1'b1;
      end
      RESULT: begin
        w_res_valid = 1'b1;
        if (r_res_valid && res_ready) begin
          w_state     = IDLE;
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_res_valid = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
    if (abort) begin
      w_state     = IDLE;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_eng_start = 1'b0;
      w_buf_swap  = 1'b0;
      w_res_valid = 1'b0;
      w_buf_sel   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_layer     <= '0;
      r_ch        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_eng_start <= 1'b0;
      r_buf_swap  <= 1'b0;
      r_buf_sel   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_layer     <= w_layer;
      r_ch        <= w_ch;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_eng_start <= w_eng_start;
      r_buf_swap  <= w_buf_swap;
      r_buf_sel   <= w_buf_sel;
      r_res_valid <= w_res_valid;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign eng_start = r_eng_start;
  assign eng_layer = r_layer;
  assign eng_ch    = r_ch;
  assign buf_swap  = r_buf_swap;
  assign buf_sel   = r_buf_sel;
  assign res_valid = r_res_valid;

endmodule
